// File: rtl/frogger_game_sequencer.sv
// Game-flow controller: idle/play/hit-freeze/goal-freeze/game-over, owns score, lives, level and car speed.
// Latency: every output is registered; a state change lands one clock after the triggering input is sampled.
// No backpressure: inputs are levels/pulses sampled each clock; frozen states ignore collision and goal inputs.
module frogger_game_sequencer #(
    parameter int unsigned c_LIVES      = 3,
    parameter int unsigned c_MAX_SCORE  = 99,
    parameter int unsigned c_LEVEL_PTS  = 5,
    parameter int unsigned c_BASE_SLOW  = 2000000,
    parameter int unsigned c_SLOW_STEP  = 200000,
    parameter int unsigned c_MIN_SLOW   = 400000,
    parameter int unsigned c_HIT_FRAMES = 60,
    parameter int unsigned c_WIN_FRAMES = 30
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Frame_Tick,
    input  logic        i_Game_Start,
    input  logic        i_Collided,
    input  logic        i_Frog_Home,
    output logic [2:0]  o_State,
    output logic        o_Play_En,
    output logic        o_Frog_Reset,
    output logic [6:0]  o_Score,
    output logic [1:0]  o_Lives,
    output logic [3:0]  o_Level,
    output logic [23:0] o_Slow_Count,
    output logic        o_LED_1
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAYING   = 3'd1,
        HIT       = 3'd2,
        SCORED    = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [1:0]  LIVES_INIT = 2'(c_LIVES);
    localparam logic [6:0]  MAX_SCORE  = 7'(c_MAX_SCORE);
    localparam logic [6:0]  LEVEL_PTS  = 7'(c_LEVEL_PTS);
    localparam logic [23:0] BASE_SLOW  = 24'(c_BASE_SLOW);
    localparam logic [23:0] SLOW_STEP  = 24'(c_SLOW_STEP);
    localparam logic [23:0] MIN_SLOW   = 24'(c_MIN_SLOW);
    // At or above this value a full step still lands on or above the floor,
    // so the subtraction can never wrap below zero.
    localparam logic [23:0] SLOW_KNEE  = 24'(c_MIN_SLOW + c_SLOW_STEP);
    localparam logic [7:0]  HIT_N      = 8'(c_HIT_FRAMES);
    localparam logic [7:0]  WIN_N      = 8'(c_WIN_FRAMES);

    state_t      state;
    logic        start_prev;
    logic [7:0]  frame_cnt;
    logic [6:0]  level_pts;
    logic        start_evt;
    logic [7:0]  frame_nxt;

    assign start_evt = i_Game_Start & ~start_prev;
    assign frame_nxt = frame_cnt + 8'd1;
    assign o_State   = state;

    // Session sequencer: state, counters and all registered outputs in one place.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state        <= IDLE;
            start_prev   <= 1'b1;
            frame_cnt    <= 8'd0;
            level_pts    <= 7'd0;
            o_Play_En    <= 1'b0;
            o_Frog_Reset <= 1'b0;
            o_Score      <= 7'd0;
            o_Lives      <= LIVES_INIT;
            o_Level      <= 4'd0;
            o_Slow_Count <= BASE_SLOW;
            o_LED_1      <= 1'b0;
        end else begin
            start_prev   <= i_Game_Start;
            o_Frog_Reset <= 1'b0;
            case (state)
                IDLE, GAME_OVER: begin
                    if (start_evt) begin
                        state        <= PLAYING;
                        o_Play_En    <= 1'b1;
                        o_Frog_Reset <= 1'b1;
                        o_Score      <= 7'd0;
                        o_Lives      <= LIVES_INIT;
                        o_Level      <= 4'd0;
                        level_pts    <= 7'd0;
                        o_Slow_Count <= BASE_SLOW;
                        o_LED_1      <= 1'b0;
                    end
                end
                PLAYING: begin
                    // Collision takes priority over reaching home in the same cycle.
                    if (i_Collided) begin
                        state     <= HIT;
                        o_Play_En <= 1'b0;
                        frame_cnt <= 8'd0;
                        if (o_Lives != 2'd0) begin
                            o_Lives <= o_Lives - 2'd1;
                        end
                    end else if (i_Frog_Home) begin
                        state     <= SCORED;
                        o_Play_En <= 1'b0;
                        frame_cnt <= 8'd0;
                        if (o_Score < MAX_SCORE) begin
                            o_Score <= o_Score + 7'd1;
                            if (level_pts + 7'd1 == LEVEL_PTS) begin
                                level_pts <= 7'd0;
                                if (o_Level != 4'hF) begin
                                    o_Level <= o_Level + 4'd1;
                                end
                                o_Slow_Count <= (o_Slow_Count >= SLOW_KNEE) ?
                                                (o_Slow_Count - SLOW_STEP) : MIN_SLOW;
                            end else begin
                                level_pts <= level_pts + 7'd1;
                            end
                        end
                    end
                end
                HIT: begin
                    if (i_Frame_Tick) begin
                        frame_cnt <= frame_nxt;
                        if (frame_nxt == HIT_N) begin
                            if (o_Lives == 2'd0) begin
                                state   <= GAME_OVER;
                                o_LED_1 <= 1'b1;
                            end else begin
                                state        <= PLAYING;
                                o_Play_En    <= 1'b1;
                                o_Frog_Reset <= 1'b1;
                            end
                        end
                    end
                end
                SCORED: begin
                    if (i_Frame_Tick) begin
                        frame_cnt <= frame_nxt;
                        if (frame_nxt == WIN_N) begin
                            state        <= PLAYING;
                            o_Play_En    <= 1'b1;
                            o_Frog_Reset <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_Play_En <= 1'b0;
                end
            endcase
        end
    end

endmodule
